fifo_burst_reader: RTL and testbench

FIFO_BURST_READER -- requirements
Module: fifo_burst_reader

---
 rtl/fifo_burst_reader.sv | 123 ++++++++++++
 tb/tb_fifo_burst_reader.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_burst_reader.sv
// Burst reader: drains fixed-length bursts from a showahead FIFO into a 2-entry
// skid buffer that feeds a valid/ready stream, with last_o marking each burst end.
module fifo_burst_reader #(
  parameter int DWIDTH    = 64,
  parameter int AWIDTH    = 15,
  parameter int BURST_LEN = 16
) (
  input  logic              clk_i,
  input  logic              arst_n_i,
  input  logic [DWIDTH-1:0] q_i,
  input  logic              empty_i,
  input  logic [AWIDTH:0]   usedw_i,
  output logic              rdreq_o,
  output logic [DWIDTH-1:0] data_o,
  output logic              valid_o,
  input  logic              ready_i,
  output logic              last_o,
  output logic              busy_o
);

  localparam int              CW        = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [CW-1:0]   CNT_MAX   = CW'(BURST_LEN - 1);
  localparam logic [AWIDTH:0] BURST_THR = (AWIDTH + 1)'(BURST_LEN);

  typedef enum logic {
    IDLE = 1'b0,
    READ = 1'b1
  } state_t;

  state_t            r_state;
  logic [CW-1:0]     r_rd_cnt;
  logic [CW-1:0]     r_out_cnt;
  logic [DWIDTH-1:0] r_buf0;
  logic [DWIDTH-1:0] r_buf1;
  logic [1:0]        r_occ;
  logic              w_push;
  logic              w_pop;

  // Handshake: a word moves downstream in any cycle where valid_o and ready_i
  // are both high; while valid_o=1 and ready_i=0 data_o/last_o are held.
  // The pop side never looks at ready_i, only at the registered occupancy, so
  // the buffer always has a free slot for the word it requests.
  assign w_push  = (r_state == READ) && !empty_i && (r_occ != 2'd2);
  assign w_pop   = (r_occ != 2'd0) && ready_i;
  assign rdreq_o = w_push;
  assign valid_o = (r_occ != 2'd0);
  assign data_o  = r_buf0;
  assign last_o  = valid_o && (r_out_cnt == CNT_MAX);
  assign busy_o  = (r_state == READ);

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      r_state  <= IDLE;
      r_rd_cnt <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (usedw_i >= BURST_THR) begin
            r_state  <= READ;
            r_rd_cnt <= '0;
          end
        end
        READ: begin
          if (w_push) begin
            if (r_rd_cnt == CNT_MAX) begin
              r_state  <= IDLE;
              r_rd_cnt <= '0;
            end else begin
              r_rd_cnt <= r_rd_cnt + 1'b1;
            end
          end
        end
        default: begin
          r_state  <= IDLE;
          r_rd_cnt <= '0;
        end
      endcase
    end
  end

  // Entry 0 is always the oldest word; a pop shifts entry 1 forward.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      r_buf0 <= '0;
      r_buf1 <= '0;
      r_occ  <= 2'd0;
    end else begin
      case ({w_push, w_pop})
        2'b10: begin
          if (r_occ == 2'd0) begin
            r_buf0 <= q_i;
          end else begin
            r_buf1 <= q_i;
          end
          r_occ <= r_occ + 2'd1;
        end
        2'b01: begin
          r_buf0 <= r_buf1;
          r_occ  <= r_occ - 2'd1;
        end
        2'b11: begin
          r_buf0 <= q_i;
        end
        default: begin
          r_occ <= r_occ;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      r_out_cnt <= '0;
    end else if (w_pop) begin
      if (r_out_cnt == CNT_MAX) begin
        r_out_cnt <= '0;
      end else begin
        r_out_cnt <= r_out_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Bench for fifo_burst_reader: three instances (BURST_LEN 1, 4, 16) fed by
// queue-based upstream FIFO models, checked by an in-order scoreboard.
module tb_fifo_burst_reader;

  localparam int DW = 16;
  localparam int AW = 6;

  logic          clk    = 1'b0;
  logic          arst_n = 1'b1;
  logic [DW-1:0] q     [3];
  logic [DW-1:0] data  [3];
  logic          empty [3];
  logic          rdreq [3];
  logic          valid [3];
  logic          ready [3];
  logic          last  [3];
  logic          busy  [3];
  logic [AW:0]   usedw [3];

  always #5 clk = ~clk;

  fifo_burst_reader #(.DWIDTH(DW), .AWIDTH(AW), .BURST_LEN(1)) u_dut0 (
    .clk_i(clk), .arst_n_i(arst_n), .q_i(q[0]), .empty_i(empty[0]), .usedw_i(usedw[0]),
    .rdreq_o(rdreq[0]), .data_o(data[0]), .valid_o(valid[0]), .ready_i(ready[0]),
    .last_o(last[0]), .busy_o(busy[0]));

  fifo_burst_reader #(.DWIDTH(DW), .AWIDTH(AW), .BURST_LEN(4)) u_dut1 (
    .clk_i(clk), .arst_n_i(arst_n), .q_i(q[1]), .empty_i(empty[1]), .usedw_i(usedw[1]),
    .rdreq_o(rdreq[1]), .data_o(data[1]), .valid_o(valid[1]), .ready_i(ready[1]),
    .last_o(last[1]), .busy_o(busy[1]));

  fifo_burst_reader #(.DWIDTH(DW), .AWIDTH(AW), .BURST_LEN(16)) u_dut2 (
    .clk_i(clk), .arst_n_i(arst_n), .q_i(q[2]), .empty_i(empty[2]), .usedw_i(usedw[2]),
    .rdreq_o(rdreq[2]), .data_o(data[2]), .valid_o(valid[2]), .ready_i(ready[2]),
    .last_o(last[2]), .busy_o(busy[2]));

  // Upstream FIFO model and scoreboard state
  logic [DW-1:0] mem     [3][256];
  logic [DW-1:0] exp_q   [3][$];
  int            wp      [3];
  int            rp_base [3];
  int            pops    [3];
  int            outs    [3];
  int            lasts   [3];
  int            out_idx [3];
  logic          rdy_n   [3];
  logic          stall_p [3];
  logic [DW-1:0] data_p  [3];
  logic          last_p  [3];
  logic [DW-1:0] mon_d;
  int            hs_cyc[$];
  int            cyc;
  bit            flicker;
  int            checks;
  int            errors;

  function automatic int bl_of(input int i);
    return (i == 0) ? 1 : ((i == 1) ? 4 : 16);
  endfunction

  function automatic int rp_of(input int i);
    return rp_base[i] + pops[i];
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fifo_write(input int i, input logic [DW-1:0] d);
    mem[i][wp[i] % 256] = d;
    wp[i]++;
    exp_q[i].push_back(d);
  endtask

  task automatic drive();
    for (int i = 0; i < 3; i++) begin
      empty[i] = (wp[i] == rp_of(i)) || (flicker && i == 1 && (cyc % 2) == 1);
      usedw[i] = (AW + 1)'(wp[i] - rp_of(i));
      q[i]     = (wp[i] == rp_of(i)) ? '0 : mem[i][rp_of(i) % 256];
      ready[i] = rdy_n[i];
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    drive();
    #1;
  endtask

  task automatic do_reset();
    arst_n = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst_lane%0d_rdreq", i), 64'(rdreq[i]), 0);
      chk($sformatf("rst_lane%0d_valid", i), 64'(valid[i]), 0);
      chk($sformatf("rst_lane%0d_last", i), 64'(last[i]), 0);
      chk($sformatf("rst_lane%0d_busy", i), 64'(busy[i]), 0);
      chk($sformatf("rst_lane%0d_data", i), 64'(data[i]), 0);
      exp_q[i].delete();
      rp_base[i] = wp[i] - pops[i];
    end
    drive();
    step();
    step();
    arst_n = 1'b1;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int k;
    k = 0;
    while ((exp_q[0].size() != 0 || exp_q[1].size() != 0 || exp_q[2].size() != 0) && k < budget) begin
      step();
      k++;
    end
    chk({name, "_drain_in_budget"}, 64'(k < budget), 1);
    repeat (3) step();
  endtask

  // Monitor: samples on the falling edge, away from the DUT's active edge.
  always @(negedge clk) begin
    if (!arst_n) begin
      for (int i = 0; i < 3; i++) begin
        out_idx[i] = 0;
        stall_p[i] = 1'b0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (rdreq[i]) begin
          pops[i]++;
          chk($sformatf("lane%0d_pop_on_empty", i), 64'(empty[i]), 0);
        end
        if (stall_p[i]) begin
          chk($sformatf("lane%0d_hold_valid", i), 64'(valid[i]), 1);
          chk($sformatf("lane%0d_hold_data", i), 64'(data[i]), 64'(data_p[i]));
          chk($sformatf("lane%0d_hold_last", i), 64'(last[i]), 64'(last_p[i]));
        end
        if (valid[i] && ready[i]) begin
          if (exp_q[i].size() == 0) begin
            checks++;
            errors++;
            $display("FAIL lane%0d_unexpected_word: got 0x%0h expected no word", i, data[i]);
          end else begin
            mon_d = exp_q[i].pop_front();
            chk($sformatf("lane%0d_data", i), 64'(data[i]), 64'(mon_d));
            chk($sformatf("lane%0d_last", i), 64'(last[i]),
                64'((out_idx[i] % bl_of(i)) == bl_of(i) - 1));
          end
          out_idx[i]++;
          outs[i]++;
          if (last[i]) lasts[i]++;
          if (i == 1) hs_cyc.push_back(cyc);
        end
        stall_p[i] = valid[i] && !ready[i];
        data_p[i]  = data[i];
        last_p[i]  = last[i];
      end
    end
  end

  initial begin
    int p0, o0, l0, k;
    int tw[3], wr[3], ob[3], pb[3], lb[3];
    bit any_rd, any_vl, any_bs;
    checks  = 0;
    errors  = 0;
    cyc     = 0;
    flicker = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wp[i] = 0; rp_base[i] = 0; pops[i] = 0; outs[i] = 0; lasts[i] = 0;
      out_idx[i] = 0; rdy_n[i] = 1'b1; stall_p[i] = 1'b0; data_p[i] = '0; last_p[i] = 1'b0;
    end
    drive();
    #3;
    do_reset();

    // Below-threshold fill must not start a burst
    for (int i = 0; i < 3; i++) fifo_write(1, DW'(16'hA0 + i));
    any_rd = 0; any_vl = 0; any_bs = 0;
    repeat (8) begin
      step();
      any_rd |= rdreq[1];
      any_vl |= valid[1];
      any_bs |= busy[1];
    end
    chk("r034_rdreq", 64'(any_rd), 0);
    chk("r034_valid", 64'(any_vl), 0);
    chk("r034_busy", 64'(any_bs), 0);

    // Two back-to-back bursts of 4 with ready held high
    hs_cyc.delete();
    p0 = pops[1]; o0 = outs[1]; l0 = lasts[1];
    for (int i = 3; i < 8; i++) fifo_write(1, DW'(16'hA0 + i));
    wait_drain("r035", 100);
    chk("r035_pops", 64'(pops[1] - p0), 8);
    chk("r035_outs", 64'(outs[1] - o0), 8);
    chk("r035_lasts", 64'(lasts[1] - l0), 2);
    chk("r035_hs_count", 64'(hs_cyc.size()), 8);
    if (hs_cyc.size() == 8) begin
      chk("r035_burst1_consecutive", 64'(hs_cyc[3] - hs_cyc[0]), 3);
      chk("r035_burst2_consecutive", 64'(hs_cyc[7] - hs_cyc[4]), 3);
    end
    chk("r035_busy_after", 64'(busy[1]), 0);

    // Downstream stall fills the buffer and throttles pops
    p0 = pops[1]; o0 = outs[1];
    for (int i = 0; i < 8; i++) fifo_write(1, DW'(16'hB0 + i));
    k = 0;
    while (outs[1] - o0 < 2 && k < 50) begin
      step();
      k++;
    end
    chk("r036_start_in_budget", 64'(k < 50), 1);
    rdy_n[1] = 1'b0;
    repeat (6) step();
    chk("r036_stall_rdreq", 64'(rdreq[1]), 0);
    chk("r036_stall_valid", 64'(valid[1]), 1);
    chk("r036_stall_occupancy", 64'((pops[1] - p0) - (outs[1] - o0)), 2);
    rdy_n[1] = 1'b1;
    wait_drain("r036", 100);
    chk("r036_pops", 64'(pops[1] - p0), 8);
    chk("r036_outs", 64'(outs[1] - o0), 8);

    // Empty flag flickering every cycle
    flicker = 1'b1;
    p0 = pops[1]; o0 = outs[1];
    for (int i = 0; i < 4; i++) fifo_write(1, DW'(16'hC0 + i));
    wait_drain("r037", 100);
    chk("r037_pops", 64'(pops[1] - p0), 4);
    chk("r037_outs", 64'(outs[1] - o0), 4);
    flicker = 1'b0;

    // Reset in the middle of a burst, then a fresh burst
    o0 = outs[1];
    for (int i = 0; i < 4; i++) fifo_write(1, DW'(16'hD0 + i));
    k = 0;
    while (outs[1] - o0 < 2 && k < 50) begin
      step();
      k++;
    end
    chk("r038_start_in_budget", 64'(k < 50), 1);
    do_reset();
    o0 = outs[1]; l0 = lasts[1]; p0 = pops[1];
    for (int i = 0; i < 4; i++) fifo_write(1, DW'(16'hE0 + i));
    wait_drain("r038", 100);
    chk("r038_outs", 64'(outs[1] - o0), 4);
    chk("r038_pops", 64'(pops[1] - p0), 4);
    chk("r038_lasts", 64'(lasts[1] - l0), 1);

    // Randomized traffic: 400 + 400 + 200 = 1000 bursts
    tw[0] = 400 * 1; tw[1] = 400 * 4; tw[2] = 200 * 16;
    for (int i = 0; i < 3; i++) begin
      wr[i] = 0; ob[i] = outs[i]; pb[i] = pops[i]; lb[i] = lasts[i];
    end
    k = 0;
    while (k < 40000 && (wr[0] < tw[0] || wr[1] < tw[1] || wr[2] < tw[2] ||
           exp_q[0].size() != 0 || exp_q[1].size() != 0 || exp_q[2].size() != 0)) begin
      for (int i = 0; i < 3; i++) begin
        for (int n = $urandom_range(0, 2); n > 0; n--) begin
          if (wr[i] < tw[i] && (wp[i] - rp_of(i)) < 56) begin
            fifo_write(i, DW'($urandom));
            wr[i]++;
          end
        end
        rdy_n[i] = ($urandom_range(0, 9) < 7);
      end
      step();
      k++;
    end
    chk("r039_in_budget", 64'(k < 40000), 1);
    for (int i = 0; i < 3; i++) rdy_n[i] = 1'b1;
    repeat (4) step();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("r039_lane%0d_outs", i), 64'(outs[i] - ob[i]), 64'(tw[i]));
      chk($sformatf("r039_lane%0d_pops", i), 64'(pops[i] - pb[i]), 64'(tw[i]));
      chk($sformatf("r039_lane%0d_lasts", i), 64'(lasts[i] - lb[i]), 64'(tw[i] / bl_of(i)));
      chk($sformatf("r039_lane%0d_busy_end", i), 64'(busy[i]), 0);
      chk($sformatf("r039_lane%0d_valid_end", i), 64'(valid[i]), 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
